// File: rtl/an_pkg.sv
// rtl/an_pkg.sv - shared constants and result type for the A=13 AN-code decode path
package an_pkg;

   localparam int AN_A    = 13;
   localparam int AN_CW_W = 6;
   localparam int AN_Q_W  = 3;
   localparam int AN_R_W  = 4;

   // One decoded codeword: quotient is the data, residue nonzero flags corruption
   typedef struct packed {
      logic [AN_Q_W-1:0] q;
      logic [AN_R_W-1:0] r;
      logic              error;
   } an_result_t;

endpackage

// File: rtl/barrett_n13.sv
// rtl/barrett_n13.sv - combinational Barrett divide-by-13 for 6-bit AN codewords
module barrett_n13
   import an_pkg::*;
(
   input  logic [AN_CW_W-1:0] codeword,
   output logic [AN_Q_W-1:0]  q,
   output logic [AN_R_W-1:0]  r,
   output logic               error,
   output logic [AN_Q_W-1:0]  dbg_q_est,
   output logic               dbg_corr
);

   // floor(2^8 / 13): the estimate is low by at most one over the 6-bit range
   localparam logic [10:0] BM = 11'((1 << 8) / AN_A);

   logic [10:0] prod;
   logic [5:0]  qa;
   logic [5:0]  r_est;
   logic [5:0]  r_fix;
   logic [2:0]  q_est;
   logic        corr;
   logic        unused_bits;

   // Estimate quotient by reciprocal multiply, then one conditional correction step
   always_comb begin
      prod  = {5'd0, codeword} * BM;
      q_est = prod[10:8];
      qa    = {3'd0, q_est} * 6'(AN_A);
      r_est = codeword - qa;
      corr  = (r_est >= 6'(AN_A));
      r_fix = corr ? (r_est - 6'(AN_A)) : r_est;
      q     = corr ? (q_est + 3'd1) : q_est;
      r     = r_fix[3:0];
      error = (r_fix[3:0] != 4'd0);
   end

   assign dbg_q_est   = q_est;
   assign dbg_corr    = corr;
   assign unused_bits = ^{prod[7:0], r_fix[5:4]};

endmodule

// File: rtl/an_decode_sched.sv
// rtl/an_decode_sched.sv - two-requester round-robin front end for one barrett_n13 decoder (optional error counter: AN_SCHED_ERR_CNT_EN)
module an_decode_sched
   import an_pkg::*;
#(
   parameter int A     = AN_A,
   parameter int CW_W  = AN_CW_W,
   parameter int Q_W   = AN_Q_W,
   parameter int R_W   = AN_R_W,
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [CW_W-1:0]  req0_word,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [CW_W-1:0]  req1_word,
   output logic             req1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src,
   output logic [Q_W-1:0]   out_q,
   output logic [R_W-1:0]   out_r,
   output logic             out_error,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // The decoder is hard-wired for A=13 and its widths
   if (A != AN_A || CW_W != AN_CW_W || Q_W != AN_Q_W || R_W != AN_R_W) begin : g_param_check
      $error("an_decode_sched: A/width parameters must match barrett_n13");
   end

   logic            s1_valid_q, s1_valid_d;
   logic [CW_W-1:0] s1_word_q, s1_word_d;
   logic            s1_src_q, s1_src_d;
   logic            out_valid_q, out_valid_d;
   logic            out_src_q, out_src_d;
   an_result_t      res_q, res_d;
   logic            rr_ptr_q, rr_ptr_d;
   an_result_t      dec;
   logic            advance, grant0, grant1, accept;
   logic [Q_W-1:0]  unused_q_est;
   logic            unused_corr;

   barrett_n13 u_barrett (
      .codeword  (s1_word_q),
      .q         (dec.q),
      .r         (dec.r),
      .error     (dec.error),
      .dbg_q_est (unused_q_est),
      .dbg_corr  (unused_corr)
   );

   // Arbitrate, then move S1->S2 and accept a new word whenever the output is free
   always_comb begin
      advance     = !out_valid_q || out_ready;
      grant1      = req1_valid && (!req0_valid || rr_ptr_q);
      grant0      = req0_valid && !grant1;
      accept      = (req0_valid || req1_valid) && advance;
      s1_valid_d  = s1_valid_q;
      s1_word_d   = s1_word_q;
      s1_src_d    = s1_src_q;
      out_valid_d = out_valid_q;
      out_src_d   = out_src_q;
      res_d       = res_q;
      rr_ptr_d    = rr_ptr_q;
      if (advance) begin
         s1_valid_d  = accept;
         s1_word_d   = grant1 ? req1_word : req0_word;
         s1_src_d    = grant1;
         out_valid_d = s1_valid_q;
         out_src_d   = s1_src_q;
         res_d       = dec;
      end
      // The loser of this grant gets priority next time
      if (accept) begin
         rr_ptr_d = !grant1;
      end
   end

   // Pipeline and arbiter state; reset drops anything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_word_q   <= '0;
         s1_src_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         res_q       <= '0;
         rr_ptr_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_word_q   <= s1_word_d;
         s1_src_q    <= s1_src_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         res_q       <= res_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Readies are forced low while reset is held
   assign req0_ready = grant0 && advance && rst_n;
   assign req1_ready = grant1 && advance && rst_n;
   assign out_valid  = out_valid_q;
   assign out_src    = out_src_q;
   assign out_q      = res_q.q;
   assign out_r      = res_q.r;
   assign out_error  = res_q.error;

`ifdef AN_SCHED_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Count delivered bad codewords, saturating; clear wins over increment
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (out_valid_q && out_ready && res_q.error && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Error counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_an_decode_sched.sv
// tb/tb_an_decode_sched.sv - self-checking bench for an_decode_sched against a queue-based reference model
module tb_an_decode_sched;

`ifdef AN_SCHED_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   localparam int CNT_MAX = (1 << 8) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [5:0] req0_word = '0, req1_word = '0;
   logic       req0_ready, req1_ready;
   logic       out_valid, out_src, out_error;
   logic       out_ready = 1'b0;
   logic [2:0] out_q;
   logic [3:0] out_r;
   logic       clr_cnt = 1'b0;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       src;
      bit [5:0] word;
      int       acc;
   } ent_t;

   ent_t     sb[$];
   bit [5:0] q0[$];
   bit [5:0] q1[$];
   bit       glog[$];
   int       cyc = 0;
   bit       rr_m = 1'b0;
   int       cnt_m = 0;
   bit       prev_stall = 1'b0;
   logic [8:0] prev_out = '0;

   an_decode_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_word  (req0_word),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_word  (req1_word),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_src    (out_src),
      .out_q      (out_q),
      .out_r      (out_r),
      .out_error  (out_error),
      .clr_cnt    (clr_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of requester/consumer activity, entered and left at posedge+1
   task automatic step(input bit en0, input bit en1, input bit ordy, input bit clr);
      req0_valid = en0 && (q0.size() > 0);
      req0_word  = req0_valid ? q0[0] : 6'd0;
      req1_valid = en1 && (q1.size() > 0);
      req1_word  = req1_valid ? q1[0] : 6'd0;
      out_ready  = ordy;
      clr_cnt    = clr;
      @(negedge clk);
      if (req0_valid && req0_ready) begin
         void'(q0.pop_front());
         glog.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
         void'(q1.pop_front());
         glog.push_back(1'b1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_empty(input bit ordy, input int bound);
      for (int i = 0; i < bound && (q0.size() > 0 || q1.size() > 0); i++) step(1'b1, 1'b1, ordy, 1'b0);
      chk("sent_all", q0.size() + q1.size(), 0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("drained", sb.size(), 0);
   endtask

   // Reference model: arbitration rule, in-order delivery, 2-cycle latency, error count
   always @(negedge clk) begin
      bit   exp_ov, stall, hs, g;
      int   rv;
      ent_t e;
      rv = 0;
      if (!rst_n) begin
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_err_cnt", err_cnt, 0);
         sb.delete();
         rr_m       = 1'b0;
         cnt_m      = 0;
         prev_stall = 1'b0;
      end else begin
         chk("err_cnt", err_cnt, CNT_EN ? cnt_m : 0);
         exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 1);
         chk("out_valid", out_valid, exp_ov);
         if (prev_stall) chk("stable", {out_src, out_q, out_r, out_error}, prev_out);
         stall = exp_ov && !out_ready;
         hs    = exp_ov && out_ready;
         if (hs) begin
            e  = sb.pop_front();
            rv = e.word % 13;
            chk("out_src", out_src, e.src);
            chk("out_q", out_q, e.word / 13);
            chk("out_r", out_r, rv);
            chk("out_error", out_error, rv != 0);
         end
         if (clr_cnt) cnt_m = 0;
         else if (hs && rv != 0 && cnt_m < CNT_MAX) cnt_m++;
         if (stall) begin
            chk("stall_ready0", req0_ready, 0);
            chk("stall_ready1", req1_ready, 0);
         end else if (req0_valid && req1_valid) begin
            chk("rr_ready0", req0_ready, rr_m == 1'b0);
            chk("rr_ready1", req1_ready, rr_m == 1'b1);
         end else begin
            chk("solo_ready0", req0_ready, req0_valid);
            chk("solo_ready1", req1_ready, req1_valid);
         end
         if (!stall && (req0_valid || req1_valid)) begin
            g = (req0_valid && req1_valid) ? rr_m : req1_valid;
            sb.push_back('{g, g ? req1_word : req0_word, cyc + 1});
            rr_m = !g;
         end
         prev_stall = stall;
         prev_out   = {out_src, out_q, out_r, out_error};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_g [6];
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state, with requests pending so readies are exercised
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_word  = 6'd5;
      req1_word  = 6'd7;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_src", out_src, 0);
      chk("reset_out_q", out_q, 0);
      chk("reset_out_r", out_r, 0);
      chk("reset_out_error", out_error, 0);
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;

      // Single words, two-cycle latency
      q0.push_back(6'd13);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("single0_valid", out_valid, 1);
      chk("single0_src", out_src, 0);
      chk("single0_q", out_q, 1);
      chk("single0_r", out_r, 0);
      chk("single0_err", out_error, 0);
      q1.push_back(6'd27);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("single1_valid", out_valid, 1);
      chk("single1_src", out_src, 1);
      chk("single1_q", out_q, 2);
      chk("single1_r", out_r, 1);
      chk("single1_err", out_error, 1);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);

      // Contention from rr_ptr=0
      glog.delete();
      q0 = '{6'd13, 6'd26, 6'd39};
      q1 = '{6'd52, 6'd53, 6'd63};
      run_until_empty(1'b1, 20);
      chk("grant_count", glog.size(), 6);
      for (int k = 0; k < 6 && k < glog.size(); k++) chk($sformatf("grant_%0d", k), glog[k], exp_g[k]);

      // Backpressure: only two words enter before the pipe fills
      for (int k = 0; k < 4; k++) begin
         q0.push_back(6'($urandom_range(0, 63)));
         q1.push_back(6'($urandom_range(0, 63)));
      end
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("bp_pending", q0.size() + q1.size(), 6);
      run_until_empty(1'b1, 30);

      // Error counter: three bad words out of four
      step(1'b0, 1'b0, 1'b1, 1'b1);
      q0 = '{6'd38, 6'd1, 6'd2, 6'd13};
      run_until_empty(1'b1, 20);
      chk("cnt_three", err_cnt, CNT_EN ? 3 : 0);

      // Clear held across an error handshake
      q0.push_back(6'd1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("cnt_clr", err_cnt, 0);

      // Saturation
      for (int k = 0; k < 256; k++) q0.push_back(6'd1);
      run_until_empty(1'b1, 400);
      chk("cnt_sat", err_cnt, CNT_EN ? CNT_MAX : 0);
      q1.push_back(6'd40);
      run_until_empty(1'b1, 10);
      chk("cnt_sat_hold", err_cnt, CNT_EN ? CNT_MAX : 0);

      // Randomized traffic with random backpressure and clears
      for (int i = 0; i < 400; i++) begin
         if (q0.size() < 2) q0.push_back(6'($urandom_range(0, 63)));
         if (q1.size() < 2) q1.push_back(6'($urandom_range(0, 63)));
         step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 32) == 0);
      end
      run_until_empty(1'b1, 50);

      // Async reset with S1 and S2 occupied
      for (int k = 0; k < 3; k++) begin
         q0.push_back(6'($urandom_range(0, 63)));
         q1.push_back(6'($urandom_range(0, 63)));
      end
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_q", out_q, 0);
      chk("arst_out_r", out_r, 0);
      chk("arst_out_error", out_error, 0);
      chk("arst_out_src", out_src, 0);
      chk("arst_ready0", req0_ready, 0);
      chk("arst_ready1", req1_ready, 0);
      chk("arst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      glog.delete();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("arst_grant_count", glog.size(), 1);
      if (glog.size() > 0) chk("arst_first_grant", glog[0], 0);
      run_until_empty(1'b1, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/an_decode_sched.md
Name: an_decode_sched

Overview:
- Round-robin scheduler that shares one barrett_n13 AN-code decoder (A=13, 6-bit codeword) between two requesters.
- Accepts codewords on valid/ready ports, registers the arbitrated word in front of the combinational Barrett datapath, and registers q/r/error plus source tag at the output.
- Keeps a saturating count of delivered codewords with nonzero residue.
- Sits between codeword producers and the downstream data consumer.

Parameters:
- A, 13, AN-code constant (fixed by barrett_n13; checked at elaboration)
- CW_W, 6, codeword width
- Q_W, 3, quotient width
- R_W, 4, residue width
- CNT_W, 8, error counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 word valid
- req0_word  in  CW_W  requester 0 codeword
- req0_ready  out  1  requester 0 accepted this cycle when valid
- req1_valid  in  1  requester 1 word valid
- req1_word  in  CW_W  requester 1 codeword
- req1_ready  out  1  requester 1 accepted this cycle when valid
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_src  out  1  requester index of result
- out_q  out  Q_W  decoded quotient (data)
- out_r  out  R_W  residue
- out_error  out  1  residue nonzero
- clr_cnt  in  1  synchronous clear of err_cnt
- err_cnt  out  CNT_W  saturating error count

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_src=0, out_q=0, out_r=0, out_error=0, err_cnt=0, rr_ptr=0. Both ready outputs are 0 while in reset.
- Two-stage pipeline:
  - S1 holds word and src.
  - barrett_n13 operates on the S1 word combinationally.
  - S2 (output register) captures q, r, error and src.
- advance = !out_valid | out_ready.
  - S2 loads from S1 when advance; out_valid_next = s1_valid.
  - S1 loads when advance; s1_valid_next = accept.
- Latency: word accepted at edge N appears on outputs after edge N+1 (2 cycles). Sustained throughput is 1 word/cycle while out_ready=1.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - reqX_ready = grant_X & advance; accept = any valid & advance.
- rr_ptr updates only on accept: it becomes the index of the non-granted requester. No update when stalled or idle.
- Stall (out_valid=1, out_ready=0): S1/S2 hold, both ready=0, held words are not dropped.
- Output stability: out_* is held stable while out_valid=1 and out_ready=0.
- Counter:
  - On output handshake with out_error=1, err_cnt increments and saturates at 2^CNT_W-1.
  - clr_cnt has priority: when coincident with an increment, the result is 0.
- Reset mid-operation: in-flight words in S1/S2 are discarded. The requester must re-present.
- Arithmetic: q = floor(word/13) and r = word mod 13, both from barrett_n13. error = (r != 0). For 6-bit input q ≤ 4 and r ≤ 12.

Optional Feature:
- Macro: AN_SCHED_ERR_CNT_EN.
- Defined: err_cnt/clr_cnt behave as above.
- Undefined: no counter flops; err_cnt tied to 0 and clr_cnt ignored. The rest of the block is unchanged.

Decomposition:
- Package an_pkg holds:
  - constants AN_A=13, AN_CW_W=6, AN_Q_W=3, AN_R_W=4
  - typedef an_result_t {q, r, error}
- Sub-module: the existing barrett_n13, instantiated once. Only codeword, q, r and error are used; debug outputs are left unconnected.
- Arbiter kept inline; no further sub-module.

Test Plan:
- Single: req0 word=13, out_ready=1 → after 2 cycles out_valid=1, src=0, q=1, r=0, error=0. req1 word=27 → src=1, q=2, r=1, error=1.
- Contention: both valid every cycle, req0 words 13,26,39, req1 words 52,53,63, starting from rr_ptr=0.
  - Grant order is 0,1,0,1,0,1.
  - Outputs in order: (0,1,0), (1,4,0), (0,2,0), (1,4,1,err), (0,3,0), (1,4,11,err).
- Backpressure: hold out_ready=0 for 5 cycles with both valid → ready=0 throughout, outputs stable, no loss. Release → results resume in order.
- Counter: deliver 38, 1, 2 (errors) and 13 → err_cnt=3. Pulse clr_cnt coincident with an error handshake → err_cnt=0. Force 255 errors then one more → err_cnt=255 (CNT_W=8).
- Async reset: assert rst_n=0 mid-burst with S1/S2 full → outputs zero immediately, rr_ptr=0. Deassert → first grant honors rr_ptr=0.
- Macro off: repeat the counter test → err_cnt stays 0; all data results match the enabled build.
